// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, sequencer state encoding and
// the width of the ALU latency counter.
package alu_pkg;

   localparam logic [2:0] OP_AND = 3'd0;
   localparam logic [2:0] OP_ADD = 3'd1;
   localparam logic [2:0] OP_LDA = 3'd2;
   localparam logic [2:0] OP_CMA = 3'd3;
   localparam logic [2:0] OP_CIR = 3'd4;
   localparam logic [2:0] OP_CIL = 3'd5;
   localparam logic [2:0] OP_INC = 3'd6;
   localparam logic [2:0] OP_CLA = 3'd7;

   localparam int CNT_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

endpackage

// File: rtl/alu_op_sequencer.sv
// Issues one ALU operation at a time, waits out the ALU latency, captures
// ALU_out into the accumulator and returns it over a valid/ready handshake.
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int W           = 16,
   parameter int ALU_LATENCY = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [2:0]   req_op,
   input  logic [W-1:0] req_operand,
   output logic [2:0]   alu_ctrl,
   output logic [W-1:0] alu_ac,
   output logic [W-1:0] alu_dr,
   input  logic [W-1:0] alu_out,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [W-1:0] rsp_data,
   output logic         ac_zero,
   output logic         busy
);

   localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(ALU_LATENCY);

   state_e             state_q, state_d;
   logic [W-1:0]       ac_q, ac_d;
   logic [W-1:0]       dr_q, dr_d;
   logic [2:0]         ctrl_q, ctrl_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         ac_q    <= '0;
         dr_q    <= '0;
         ctrl_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ac_q    <= ac_d;
         dr_q    <= dr_d;
         ctrl_q  <= ctrl_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ac_d    = ac_q;
      dr_d    = dr_q;
      ctrl_d  = ctrl_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               dr_d    = req_operand;
               ctrl_d  = req_op;
               cnt_d   = LAT_INIT;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            // Ctrl/DR stay frozen here so the ALU sees stable inputs.
            if (cnt_q == '0) begin
               ac_d    = alu_out;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign req_ready = (state_q == ST_IDLE);
   assign rsp_valid = (state_q == ST_RESP);
   assign busy      = (state_q != ST_IDLE);
   assign rsp_data  = ac_q;
   assign alu_ac    = ac_q;
   assign alu_dr    = dr_q;
   assign alu_ctrl  = ctrl_q;
   assign ac_zero   = (ac_q == '0);

endmodule
